intra_ref_fetch: RTL and testbench

Reference-row fetcher for the intra prediction engine. On a start pulse it reads the top/top-right neighbour pixels of the current PU from the 32x64 intra dual-port SRAM through its B port and streams them to the predictor as 32-bit words (4 pixels x 8 bit) over a valid/ready handshake. It absorbs the SRAM's 1-cycle read latency and predictor back-pressure with a 2-entry buffer. When neighbours are unavailable it substitutes mid-grey without touching the SRAM.

---
 rtl/intra_ref_fetch.sv | 119 +++++++++++
 tb/tb_intra_ref_fetch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/intra_ref_fetch.sv
// Reference-row fetcher: reads top/top-right neighbours from the intra SRAM B port
// and streams them as 4-pixel words over valid/ready through a 2-entry buffer.
module intra_ref_fetch #(
  parameter int                WORD_W  = 32,
  parameter int                ADDR_W  = 6,
  parameter logic [WORD_W-1:0] DC_WORD = WORD_W'(32'h8080_8080)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              avail_i,
  output logic              cenb_o,
  output logic              oenb_o,
  output logic [ADDR_W-1:0] addrb_o,
  input  logic [WORD_W-1:0] datab_i,
  output logic              ref_val_o,
  input  logic              ref_rdy_i,
  output logic [WORD_W-1:0] ref_dat_o,
  output logic              ref_last_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_base;
  logic                r_avail;
  logic [4:0]          r_issue_cnt;
  logic                r_inflight;
  logic                r_inflight_last;
  logic [WORD_W-1:0]   r_fifo_dat [2];
  logic [1:0]          r_fifo_last;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_fifo_cnt;

  logic [4:0]          w_n;
  logic                w_pop;
  logic                w_push;
  logic [2:0]          w_occ;
  logic                w_issue;

  assign w_n    = 5'd2 << r_size;
  assign w_pop  = ref_val_o & ref_rdy_i;
  assign w_push = r_inflight;
  // Occupancy the FIFO will hold once this cycle's pop and in-flight capture settle.
  assign w_occ   = 3'(r_fifo_cnt) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue = (r_state == S_FETCH) && (r_issue_cnt < w_n) && (w_occ < 3'd2);

  // Unavailable neighbours follow the same schedule but never enable the SRAM.
  assign cenb_o     = ~(w_issue & r_avail);
  assign addrb_o    = r_base + ADDR_W'(r_issue_cnt);
  assign busy_o     = (r_state != S_IDLE);
  assign oenb_o     = ~busy_o;
  assign done_o     = (r_state == S_DONE);
  assign ref_val_o  = (r_fifo_cnt != 2'd0);
  assign ref_dat_o  = r_fifo_dat[r_rd_ptr];
  assign ref_last_o = ref_val_o & r_fifo_last[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_size          <= '0;
      r_base          <= '0;
      r_avail         <= 1'b0;
      r_issue_cnt     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_dat[0]   <= '0;
      r_fifo_dat[1]   <= '0;
      r_fifo_last     <= '0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_fifo_cnt      <= '0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_issue_cnt == w_n - 5'd1);
      if (w_issue) r_issue_cnt <= r_issue_cnt + 5'd1;

      if (w_push) begin
        r_fifo_dat[r_wr_ptr]  <= r_avail ? datab_i : DC_WORD;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;

      unique case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase

      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_size      <= size_i;
            r_base      <= base_addr_i;
            r_avail     <= avail_i;
            r_issue_cnt <= '0;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_issue && (r_issue_cnt + 5'd1 == w_n)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && ref_last_o) r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intra_ref_fetch.sv
// Directed bench for intra_ref_fetch: request table plus hand-written reset sequence,
// with a behavioural 1-cycle-latency SRAM on the B port.
module tb_intra_ref_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  size_i = '0;
  logic [5:0]  base_addr_i = '0;
  logic        avail_i = 1'b0;
  logic        cenb_o, oenb_o;
  logic [5:0]  addrb_o;
  logic [31:0] datab_i;
  logic        ref_val_o;
  logic        ref_rdy_i = 1'b0;
  logic [31:0] ref_dat_o;
  logic        ref_last_o, busy_o, done_o;

  logic [31:0] mem [64];
  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  intra_ref_fetch #(.WORD_W(32), .ADDR_W(6), .DC_WORD(32'h8080_8080)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .size_i(size_i),
    .base_addr_i(base_addr_i), .avail_i(avail_i), .cenb_o(cenb_o), .oenb_o(oenb_o),
    .addrb_o(addrb_o), .datab_i(datab_i), .ref_val_o(ref_val_o), .ref_rdy_i(ref_rdy_i),
    .ref_dat_o(ref_dat_o), .ref_last_o(ref_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  // SRAM B port: data valid one cycle after an enabled read, garbage otherwise.
  always @(posedge clk) begin
    if (cenb_o === 1'b0) datab_i <= mem[addrb_o];
    else                 datab_i <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [1:0] sz;
    logic [5:0] base;
    logic       av;
    bit         rnd;
    bit         repulse;
    int         exp_n;
    int         exp_done;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run_req(input int id, input vec_t v);
    int ncen = 0, nacc = 0, first_val = 0, done_cyc = 0;
    bit addr_ok = 1, last_ok = 1, stable_ok = 1, out_ok = 1, oen_ok = 1;
    bit pstall = 0;
    logic [31:0] pdat = '0;
    logic plast = 1'b0;
    logic [5:0] a;
    logic [31:0] ew;
    @(negedge clk);
    start_i = 1'b1; size_i = v.sz; base_addr_i = v.base; avail_i = v.av; ref_rdy_i = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start_i = v.repulse && (cyc == 2);
      if (start_i) begin size_i = 2'd3; base_addr_i = 6'd40; avail_i = ~v.av; end
      ref_rdy_i = v.rnd ? ((cyc >= 4 && cyc <= 8) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
      #1;
      if (busy_o !== 1'b1 || oenb_o !== 1'b0) oen_ok = 0;
      if (cenb_o === 1'b0) begin
        if (addrb_o !== 6'(v.base + 6'(ncen))) addr_ok = 0;
        ncen++;
      end
      if (ref_val_o === 1'b1 && first_val == 0) first_val = cyc;
      if (pstall && (ref_val_o !== 1'b1 || ref_dat_o !== pdat || ref_last_o !== plast)) stable_ok = 0;
      pstall = (ref_val_o === 1'b1) && !ref_rdy_i;
      pdat = ref_dat_o;
      plast = ref_last_o;
      if (ref_val_o === 1'b1 && ref_rdy_i) begin
        a  = v.base + 6'(nacc);
        ew = v.av ? mem[a] : 32'h8080_8080;
        chk($sformatf("v%0d word%0d", id, nacc), ref_dat_o, ew);
        if (ref_last_o !== (nacc == v.exp_n - 1)) last_ok = 0;
        nacc++;
      end
      if (v.av && (ncen - nacc > 2)) out_ok = 0;
      if (done_o === 1'b1) begin done_cyc = cyc; break; end
    end
    chk($sformatf("v%0d done seen", id), 32'(done_cyc != 0), 32'd1);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d idle after done", id), {30'd0, busy_o, done_o}, 32'd0);
    chk($sformatf("v%0d word count", id), nacc, v.exp_n);
    chk($sformatf("v%0d cenb low cycles", id), ncen, v.av ? v.exp_n : 0);
    chk($sformatf("v%0d addresses", id), 32'(addr_ok), 32'd1);
    chk($sformatf("v%0d last flag", id), 32'(last_ok), 32'd1);
    chk($sformatf("v%0d stall stable", id), 32'(stable_ok), 32'd1);
    chk($sformatf("v%0d outstanding<=2", id), 32'(out_ok), 32'd1);
    chk($sformatf("v%0d busy/oenb", id), 32'(oen_ok), 32'd1);
    chk($sformatf("v%0d first valid cycle", id), first_val, 3);
    if (v.exp_done != 0) chk($sformatf("v%0d done cycle", id), done_cyc, v.exp_done);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cenb"}, 32'(cenb_o), 32'd1);
    chk({tag, " oenb"}, 32'(oenb_o), 32'd1);
    chk({tag, " addrb"}, 32'(addrb_o), 32'd0);
    chk({tag, " val"}, 32'(ref_val_o), 32'd0);
    chk({tag, " dat"}, ref_dat_o, 32'd0);
    chk({tag, " last"}, 32'(ref_last_o), 32'd0);
    chk({tag, " busy"}, 32'(busy_o), 32'd0);
    chk({tag, " done"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    mem[5] = 32'h1122_3344;
    mem[6] = 32'h5566_7788;

    //         sz    base   av    rnd repulse N   done cycle (N+3 with rdy=1)
    vecs[0] = '{2'd0, 6'd5,  1'b1, 0, 0,      2,  5};
    vecs[1] = '{2'd3, 6'd56, 1'b1, 0, 0,      16, 19};
    vecs[2] = '{2'd2, 6'd20, 1'b0, 0, 0,      8,  11};
    vecs[3] = '{2'd1, 6'd60, 1'b1, 1, 0,      4,  0};
    vecs[4] = '{2'd1, 6'd3,  1'b1, 0, 1,      4,  7};
    vecs[5] = '{2'd1, 6'd62, 1'b0, 1, 0,      4,  0};

    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) run_req(k, vecs[k]);

    // Async reset while draining a 16-word request, then a clean rerun.
    @(negedge clk);
    start_i = 1'b1; size_i = 2'd3; base_addr_i = 6'd10; avail_i = 1'b1; ref_rdy_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c < 17) @(posedge clk);
    end
    #1;
    chk("pre-reset val", 32'(ref_val_o), 32'd1);
    chk("pre-reset busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_req(6, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
